// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider bank: system clock rate, common
// half-period divisors and the channel-count ceiling.
package clock_divider_pkg;

  localparam int unsigned CLK_HZ     = 32'd100_000_000;
  localparam int unsigned DIV_1KHZ   = 32'd50_000;
  localparam int unsigned DIV_100HZ  = 32'd500_000;
  localparam int unsigned DIV_1HZ    = 32'd50_000_000;
  localparam int unsigned MAX_NUM_CH = 32'd8;

  // Half-period in system cycles for a requested output frequency.
  function automatic int unsigned hz_to_half_period(input int unsigned hz);
    if (hz == 32'd0) begin
      return 32'd0;
    end else begin
      return CLK_HZ / (32'd2 * hz);
    end
  endfunction

endpackage

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: half-period counter, active and pending divisor,
// registered square wave and rising-edge tick.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W     = 17,
  parameter int DIV_RESET = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_div,
  output logic             o_clk_out,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] r_cnt, r_div, r_pdiv;
  logic             r_pend, r_clk_out, r_tick;

  logic [CNT_W-1:0] w_cnt_nxt, w_div_nxt, w_pdiv_nxt;
  logic             w_pend_nxt, w_clk_nxt, w_tick_nxt;
  logic             w_run, w_boundary;

  assign w_run      = i_enable && (r_div != ZERO);
  assign w_boundary = w_run && (r_cnt == (r_div - ONE));

  // Next-state: sync, stop, start, then normal counting with deferred reload.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_div_nxt  = r_div;
    w_pdiv_nxt = r_pdiv;
    w_pend_nxt = r_pend;
    w_clk_nxt  = r_clk_out;
    w_tick_nxt = 1'b0;
    if (i_sync) begin
      w_cnt_nxt  = ZERO;
      w_clk_nxt  = 1'b0;
      w_pend_nxt = 1'b0;
      if (r_pend) begin
        w_div_nxt = r_pdiv;
      end else begin
        w_div_nxt = r_div;
      end
    end else if (i_load && (i_load_div == ZERO)) begin
      w_div_nxt  = ZERO;
      w_cnt_nxt  = ZERO;
      w_clk_nxt  = 1'b0;
      w_pend_nxt = 1'b0;
    end else if (i_load && (r_div == ZERO)) begin
      // Stopped channel restarts from a clean low phase.
      w_div_nxt  = i_load_div;
      w_cnt_nxt  = ZERO;
      w_pend_nxt = 1'b0;
    end else if (w_boundary) begin
      w_cnt_nxt  = ZERO;
      w_clk_nxt  = ~r_clk_out;
      w_tick_nxt = ~r_clk_out;
      w_pend_nxt = 1'b0;
      if (i_load) begin
        w_div_nxt = i_load_div;
      end else if (r_pend) begin
        w_div_nxt = r_pdiv;
      end else begin
        w_div_nxt = r_div;
      end
    end else begin
      if (w_run) begin
        w_cnt_nxt = r_cnt + ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
      if (i_load) begin
        w_pdiv_nxt = i_load_div;
        w_pend_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_pend;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= ZERO;
      r_div     <= DIV_INIT;
      r_pdiv    <= ZERO;
      r_pend    <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_pdiv    <= w_pdiv_nxt;
      r_pend    <= w_pend_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers. Defining
// CLKDIV_PHASE_SYNC_EN adds a sync input that phase-aligns all channels.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 17,
  parameter int DIV_RESET = DIV_1KHZ
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              load,
  input  logic [2:0]        load_ch,
  input  logic [CNT_W-1:0]  load_div,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              w_sync;
  logic [NUM_CH-1:0] w_load;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Indices at or above NUM_CH match no channel, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = load && (load_ch == 3'(g));

    clock_divider_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_channel (
      .i_clk      (clk_100MHz),
      .i_reset    (reset),
      .i_enable   (enable[g]),
      .i_sync     (w_sync),
      .i_load     (w_load[g]),
      .i_load_div (load_div),
      .o_clk_out  (clk_out[g]),
      .o_tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with a countdown-based reference model
// checked every cycle, plus hand-computed period and latency expectations.
module tb_clock_divider_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 17;
  localparam int DIVR   = 4;

  logic              clk_100MHz = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] enable;
  logic              load;
  logic [2:0]        load_ch;
  logic [CNT_W-1:0]  load_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic              sync;
`endif

  always #5 clk_100MHz = ~clk_100MHz;

  clock_divider_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DIV_RESET (DIVR)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_ch    (load_ch),
    .load_div   (load_div),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync       (sync),
`endif
    .clk_out    (clk_out),
    .tick       (tick)
  );

  int errors = 0;
  int checks = 0;

  // Model: half length, cycles left in current half, pending length (-1 none).
  int   m_len  [NUM_CH];
  int   m_left [NUM_CH];
  int   m_pnd  [NUM_CH];
  logic m_lvl  [NUM_CH];
  logic m_tick [NUM_CH];
  bit   m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic sy;
    logic ld;
    int   nd;
`ifdef CLKDIV_PHASE_SYNC_EN
    sy = sync;
`else
    sy = 1'b0;
`endif
    nd = int'(load_div);
    for (int c = 0; c < NUM_CH; c++) begin
      ld = load && (int'(load_ch) == c);
      if (reset) begin
        m_len[c] = DIVR; m_left[c] = DIVR; m_pnd[c] = -1;
        m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (sy) begin
        if (m_pnd[c] >= 0) m_len[c] = m_pnd[c];
        m_pnd[c] = -1; m_left[c] = m_len[c];
        m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (ld && nd == 0) begin
        m_len[c] = 0; m_left[c] = 0; m_pnd[c] = -1;
        m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (ld && m_len[c] == 0) begin
        m_len[c] = nd; m_left[c] = nd; m_pnd[c] = -1; m_tick[c] = 1'b0;
      end else if (enable[c] && m_len[c] > 0) begin
        if (m_left[c] == 1) begin
          m_lvl[c]  = !m_lvl[c];
          m_tick[c] = m_lvl[c];
          if (ld) m_len[c] = nd;
          else if (m_pnd[c] >= 0) m_len[c] = m_pnd[c];
          m_pnd[c]  = -1;
          m_left[c] = m_len[c];
        end else begin
          m_left[c]--;
          m_tick[c] = 1'b0;
          if (ld) m_pnd[c] = nd;
        end
      end else begin
        m_tick[c] = 1'b0;
        if (ld && m_len[c] > 0) m_pnd[c] = nd;
      end
    end
    if (reset) m_valid = 1'b1;
  endtask

  // One clock: advance the model from the inputs seen at the edge, compare.
  task automatic step();
    @(posedge clk_100MHz);
    #1;
    model_step();
    if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_lvl[c]));
        check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [2:0] ch, input int div);
    load = 1'b1; load_ch = ch; load_div = CNT_W'(div);
    step();
    load = 1'b0;
  endtask

  // Steps until clk_out[ch] leaves lvl; returns the number of steps taken.
  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out[ch] === lvl && n < 100);
  endtask

  task automatic wait_tick(input int ch);
    int n;
    n = 0;
    while (tick[ch] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("wait_tick timeout", 32'd0, 32'd1);
  endtask

  int n;
  int cnt_t;
  int first0, first1;

  initial begin
    reset = 1'b1; enable = '0; load = 1'b0; load_ch = 3'd0; load_div = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync = 1'b0;
`endif
    steps(2);
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset tick", 32'(tick), 32'd0);

    // First rise after reset and the 8-cycle period with DIV_RESET=4.
    reset = 1'b0; enable = 2'b11;
    steps(3);
    check("pre-rise clk_out", 32'(clk_out), 32'd0);
    step();
    check("first rise clk_out", 32'(clk_out), 32'd3);
    check("first rise tick", 32'(tick), 32'd3);
    step();
    check("tick one cycle", 32'(tick), 32'd0);
    steps(3);
    check("first fall clk_out", 32'(clk_out), 32'd0);
    steps(4);
    check("second rise tick", 32'(tick), 32'd3);

    // Channel 1: div 3, then reload 5 mid-half without a runt.
    do_load(3'd1, 3);
    steps(12);
    wait_tick(1);
    do_load(3'd1, 5);
    run_len(1, 1'b1, n);
    check("ch1 high rest", 32'(n), 32'd2);
    run_len(1, 1'b0, n);
    check("ch1 low after reload", 32'(n), 32'd5);
    run_len(1, 1'b1, n);
    check("ch1 high after reload", 32'(n), 32'd5);

    // Stop channel 0 while high, then restart with div 2.
    n = 0;
    while (clk_out[0] !== 1'b1 && n < 100) begin step(); n++; end
    do_load(3'd0, 0);
    check("stop clk_out0", 32'(clk_out[0]), 32'd0);
    check("stop tick0", 32'(tick[0]), 32'd0);
    steps(5);
    do_load(3'd0, 2);
    run_len(0, 1'b0, n);
    check("restart rise", 32'(n), 32'd2);
    check("restart tick", 32'(tick[0]), 32'd1);

    // Freeze channel 0 mid-count, resume; out-of-range load ignored.
    do_load(3'd0, 6);
    steps(15);
    enable = 2'b10;
    steps(10);
    enable = 2'b11;
    steps(12);
    do_load(3'd7, 1);
    steps(12);

    // div=1 toggles every cycle: exactly 5 ticks in 10 cycles.
    do_load(3'd0, 1);
    steps(8);
    cnt_t = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick[0] === 1'b1) cnt_t++;
    end
    check("div1 tick count", 32'(cnt_t), 32'd5);

    // Reset mid-run restores DIV_RESET.
    reset = 1'b1;
    step();
    check("midrun reset clk_out", 32'(clk_out), 32'd0);
    check("midrun reset tick", 32'(tick), 32'd0);
    reset = 1'b0;
    steps(3);
    check("post-reset pre-rise", 32'(clk_out), 32'd0);
    step();
    check("post-reset rise", 32'(clk_out), 32'd3);

`ifdef CLKDIV_PHASE_SYNC_EN
    // Phase-align div 3 and div 7 via sync.
    do_load(3'd0, 3);
    steps(2);
    do_load(3'd1, 7);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync clk_out", 32'(clk_out), 32'd0);
    check("sync tick", 32'(tick), 32'd0);
    first0 = 0; first1 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tick[0] === 1'b1 && first0 == 0) first0 = i;
      if (tick[1] === 1'b1 && first1 == 0) first1 = i;
    end
    check("sync ch0 tick", 32'(first0), 32'd3);
    check("sync ch1 tick", 32'(first1), 32'd7);
`else
    first0 = 0; first1 = 0;
`endif

    steps(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
